// File: rtl/trap_anim_scheduler.sv
// rtl/trap_anim_scheduler.sv - shared trap animation engine arbitrating pit1, pit2 and spikes
// Optional spike channel enabled by defining TRAP_SPIKE_EN.
`timescale 1ns/1ps
module trap_anim_scheduler #(
  parameter int TICK_DIV = 50000,
  parameter int STEP     = 2,
  parameter int PIT_W    = 64,
  parameter int SPIKE_H  = 16
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       death,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic       busy,
  output logic [9:0] pit1_w,
  output logic [9:0] pit2_w,
  output logic [9:0] spike_h,
  output logic [2:0] done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [9:0]    PIT_TGT   = 10'(PIT_W);
  localparam logic [9:0]    SPIKE_TGT = 10'(SPIKE_H);
  localparam logic [9:0]    STEP_V    = 10'(STEP);

`ifdef TRAP_SPIKE_EN
  localparam logic [2:0] CH_MASK = 3'b111;
`else
  localparam logic [2:0] CH_MASK = 3'b011;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t        state_q;
  logic [2:0]    grant_q;
  logic [2:0]    pending_q;
  logic [2:0]    done_q;
  logic [TW-1:0] tick_q;
  logic [9:0]    pit1_q;
  logic [9:0]    pit2_q;
`ifdef TRAP_SPIKE_EN
  logic [9:0]    spike_q;
`endif

  logic [2:0] req_acc;
  logic [2:0] pending_d;
  logic [2:0] pick;
  logic       tick_wrap;
  logic [9:0] cur_ext;
  logic [9:0] cur_tgt;
  logic [9:0] ext_d;
  logic       reach;

  // Add one step in 11 bits so the compare cannot overflow; clamp to target.
  function automatic logic [9:0] sat_step(input logic [9:0] cur, input logic [9:0] tgt);
    logic [10:0] sum;
    sum = {1'b0, cur} + {1'b0, STEP_V};
    if (sum >= {1'b0, tgt}) return tgt;
    return sum[9:0];
  endfunction

  always_comb begin
    req_acc   = req & CH_MASK & ~done_q & ~grant_q & ~pending_q;
    pending_d = pending_q | req_acc;

    if (pending_q[0])      pick = 3'b001;
    else if (pending_q[1]) pick = 3'b010;
    else if (pending_q[2]) pick = 3'b100;
    else                   pick = 3'b000;

    tick_wrap = (tick_q == TICK_LAST);

    cur_ext = pit1_q;
    cur_tgt = PIT_TGT;
    if (grant_q[1]) cur_ext = pit2_q;
    if (grant_q[2]) cur_tgt = SPIKE_TGT;
`ifdef TRAP_SPIKE_EN
    if (grant_q[2]) cur_ext = spike_q;
`endif
    ext_d = sat_step(cur_ext, cur_tgt);
    reach = (ext_d == cur_tgt);
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= 3'b000;
      pending_q <= 3'b000;
      done_q    <= 3'b000;
      tick_q    <= '0;
      pit1_q    <= 10'd0;
      pit2_q    <= 10'd0;
`ifdef TRAP_SPIKE_EN
      spike_q   <= 10'd0;
`endif
    end else if (death) begin
      // Level restart wins over everything, including same-edge requests.
      state_q   <= ST_IDLE;
      grant_q   <= 3'b000;
      pending_q <= 3'b000;
      done_q    <= 3'b000;
      tick_q    <= '0;
      pit1_q    <= 10'd0;
      pit2_q    <= 10'd0;
`ifdef TRAP_SPIKE_EN
      spike_q   <= 10'd0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pending_q != 3'b000) begin
            state_q   <= ST_RUN;
            grant_q   <= pick;
            pending_q <= pending_d & ~pick;
            tick_q    <= '0;
          end else begin
            pending_q <= pending_d;
          end
        end
        ST_RUN: begin
          pending_q <= pending_d;
          if (tick_wrap) begin
            tick_q <= '0;
            if (grant_q[0]) pit1_q <= ext_d;
            if (grant_q[1]) pit2_q <= ext_d;
`ifdef TRAP_SPIKE_EN
            if (grant_q[2]) spike_q <= ext_d;
`endif
            if (reach) state_q <= ST_FINISH;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        ST_FINISH: begin
          pending_q <= pending_d;
          done_q    <= done_q | grant_q;
          grant_q   <= 3'b000;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant  = grant_q;
  assign busy   = (state_q != ST_IDLE);
  assign pit1_w = pit1_q;
  assign pit2_w = pit2_q;
  assign done   = done_q;
`ifdef TRAP_SPIKE_EN
  assign spike_h = spike_q;
`else
  assign spike_h = 10'd0;
`endif

endmodule

// File: tb/tb_trap_anim_scheduler.sv
// tb/tb_trap_anim_scheduler.sv - scoreboard bench for trap_anim_scheduler
// Expected output snapshots are queued by the stimulus; the monitor checks each output change.
`timescale 1ns/1ps
module tb_trap_anim_scheduler;

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic       death = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] grant;
  logic       busy;
  logic [9:0] pit1_w, pit2_w, spike_h;
  logic [2:0] done;

  trap_anim_scheduler #(.TICK_DIV(4), .STEP(2), .PIT_W(8), .SPIKE_H(4)) dut (
    .Clk(Clk), .reset(reset), .death(death), .req(req),
    .grant(grant), .busy(busy), .pit1_w(pit1_w), .pit2_w(pit2_w),
    .spike_h(spike_h), .done(done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] g;
    logic       b;
    logic [9:0] p1;
    logic [9:0] p2;
    logic [9:0] s;
    logic [2:0] d;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  logic [36:0] prev_vec = '0;
  int gap_cnt = 0;
  int item_no = 0;

  task automatic push(input logic [2:0] g, input logic b, input int p1, input int p2,
                      input int s, input logic [2:0] d, input int gap);
    exp_t e;
    e.g = g; e.b = b; e.p1 = 10'(p1); e.p2 = 10'(p2); e.s = 10'(s); e.d = d; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // gap = negedges since the previous output change; 0 means not checked.
  always @(negedge Clk) begin
    logic [36:0] cur;
    exp_t e;
    cur = {grant, busy, pit1_w, pit2_w, spike_h, done};
    gap_cnt++;
    if (cur != prev_vec) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_change: got g=%b b=%b p1=%0d p2=%0d s=%0d d=%b, expected no change",
                 grant, busy, pit1_w, pit2_w, spike_h, done);
      end else begin
        e = exp_q.pop_front();
        item_no++;
        tests++;
        if (grant !== e.g || busy !== e.b || pit1_w !== e.p1 || pit2_w !== e.p2 ||
            spike_h !== e.s || done !== e.d || (e.gap != 0 && e.gap != gap_cnt)) begin
          fails++;
          $display("FAIL out_change#%0d: got g=%b b=%b p1=%0d p2=%0d s=%0d d=%b gap=%0d, expected g=%b b=%b p1=%0d p2=%0d s=%0d d=%b gap=%0d",
                   item_no, grant, busy, pit1_w, pit2_w, spike_h, done, gap_cnt,
                   e.g, e.b, e.p1, e.p2, e.s, e.d, e.gap);
        end
      end
      prev_vec = cur;
      gap_cnt = 0;
    end
  end

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic pulse_req(input logic [2:0] r);
    req = r;
    step(1);
    req = 3'b000;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_%s: got %0d pending expected changes, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_pit1(input int val, input int budget);
    int n;
    n = 0;
    while (pit1_w != 10'(val) && n < budget) begin
      step(1);
      n++;
    end
    tests++;
    if (pit1_w != 10'(val)) begin
      fails++;
      $display("FAIL wait_pit1_%0d: got %0d, expected %0d", val, pit1_w, val);
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    step(2);
    reset = 1'b0;
    chk("reset_grant", 10'(grant), 10'd0);
    chk("reset_busy", 10'(busy), 10'd0);
    chk("reset_done", 10'(done), 10'd0);
    step(2);

    // Pit1 full animation, plus a re-request while granted that must be dropped.
    push(3'b001, 1, 0, 0, 0, 3'b000, 0);
    push(3'b001, 1, 2, 0, 0, 3'b000, 4);
    push(3'b001, 1, 4, 0, 0, 3'b000, 4);
    push(3'b001, 1, 6, 0, 0, 3'b000, 4);
    push(3'b001, 1, 8, 0, 0, 3'b000, 4);
    push(3'b000, 0, 8, 0, 0, 3'b001, 1);
    pulse_req(3'b001);
    chk("lat_pending_only", 10'(grant), 10'd0);
    step(1);
    chk("lat_grant", 10'(grant), 10'd1);
    step(2);
    pulse_req(3'b001);
    drain("pit1", 60);
    step(10);

    // Request for an already-done trap.
    pulse_req(3'b001);
    step(30);
    chk("done_pit1_hold", pit1_w, 10'd8);

    // Pit2 and spikes requested together.
    push(3'b010, 1, 8, 0, 0, 3'b001, 0);
    push(3'b010, 1, 8, 2, 0, 3'b001, 4);
    push(3'b010, 1, 8, 4, 0, 3'b001, 4);
    push(3'b010, 1, 8, 6, 0, 3'b001, 4);
    push(3'b010, 1, 8, 8, 0, 3'b001, 4);
    push(3'b000, 0, 8, 8, 0, 3'b011, 1);
`ifdef TRAP_SPIKE_EN
    push(3'b100, 1, 8, 8, 0, 3'b011, 1);
    push(3'b100, 1, 8, 8, 2, 3'b011, 4);
    push(3'b100, 1, 8, 8, 4, 3'b011, 4);
    push(3'b000, 0, 8, 8, 4, 3'b111, 1);
`endif
    pulse_req(3'b110);
    drain("pit2_spike", 80);
    step(10);
`ifndef TRAP_SPIKE_EN
    pulse_req(3'b100);
    step(30);
    chk("nospike_grant", 10'(grant), 10'd0);
    chk("nospike_h", spike_h, 10'd0);
    chk("nospike_busy", 10'(busy), 10'd0);
`endif

    // Death clears everything; then death mid-animation with a same-edge request.
    push(3'b000, 0, 0, 0, 0, 3'b000, 0);
    death = 1'b1;
    step(1);
    death = 1'b0;
    drain("death_clear", 10);
    push(3'b001, 1, 0, 0, 0, 3'b000, 0);
    push(3'b001, 1, 2, 0, 0, 3'b000, 4);
    push(3'b001, 1, 4, 0, 0, 3'b000, 4);
    push(3'b000, 0, 0, 0, 0, 3'b000, 1);
    pulse_req(3'b101);
    wait_pit1(4, 60);
    death = 1'b1;
    req = 3'b010;
    step(1);
    death = 1'b0;
    req = 3'b000;
    drain("death_run", 20);
    step(30);

    // Asynchronous reset in the middle of RUN.
    push(3'b001, 1, 0, 0, 0, 3'b000, 0);
    pulse_req(3'b001);
    wait_pit1(2, 40);
    push(3'b000, 0, 0, 0, 0, 3'b000, 0);
    reset = 1'b1;
    #1;
    chk("async_grant", 10'(grant), 10'd0);
    chk("async_busy", 10'(busy), 10'd0);
    chk("async_pit1", pit1_w, 10'd0);
    step(2);
    reset = 1'b0;
    drain("async_reset", 10);
    step(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trap_anim_scheduler.md
TRAP_ANIM_SCHEDULER -- requirements
Module: trap_anim_scheduler

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000: clocks per animation tick.
REQ-002 The block SHALL have parameter STEP, default 2: pixels added per tick.
REQ-003 The block SHALL have parameter PIT_W, default 64: final pit width in pixels.
REQ-004 The block SHALL have parameter SPIKE_H, default 16: final spike height in pixels.
REQ-005 The block SHALL have port Clk, input, 1 bit: system clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port death, input, 1 bit: player died, restart level traps.
REQ-008 The block SHALL have port req, input, 3 bits: trap trigger pulses; bit0 = pit 1, bit1 = pit 2, bit2 = spikes.
REQ-009 The block SHALL have port grant, output, 3 bits: one-hot trap currently animating, or zero.
REQ-010 The block SHALL have port busy, output, 1 bit: an animation is running.
REQ-011 The block SHALL have ports pit1_w, pit2_w and spike_h, each output, 10 bits: current trap extents in pixels.
REQ-012 The block SHALL have port done, output, 3 bits: sticky per-trap completion flags.

Function
REQ-013 The single animation engine SHALL be shared among the three traps through a state machine with states IDLE, RUN and FINISH.
REQ-014 A req bit high on any edge SHALL set the matching pending bit, unless that trap is done, granted or already pending; such a request is dropped.
REQ-015 In IDLE with pending nonzero, the next edge SHALL move to RUN, set grant to the lowest-index pending bit (pit1 > pit2 > spikes), clear that pending bit and clear the tick counter.
REQ-016 A req sampled at edge n SHALL produce grant at edge n+1 when idle (1-cycle latency).
REQ-017 In RUN, the tick counter SHALL count 0..TICK_DIV-1 and wrap. On each wrap the granted extent SHALL increase by STEP, saturating at its target (PIT_W for pits, SPIKE_H for spikes; clamp if the target is not a multiple of STEP).
REQ-018 The edge on which the extent reaches its target SHALL move the machine to FINISH.
REQ-019 FINISH SHALL last exactly one cycle; it SHALL set the done bit, clear grant and return to IDLE.
REQ-020 busy SHALL be high exactly in RUN and FINISH.
REQ-021 A req arriving during RUN or FINISH SHALL be pended and served after return to IDLE.
REQ-022 Non-granted extents SHALL hold their values.
REQ-023 death SHALL have highest priority: on the next edge all extents, pending, done, grant and the tick counter SHALL go to 0 and the state to IDLE; req on the same edge SHALL be dropped.
REQ-024 Extents SHALL be 10-bit unsigned and SHALL never exceed their targets.

Reset
REQ-025 Asserting reset SHALL immediately force the state to IDLE and set grant, busy, pit1_w, pit2_w, spike_h, done, pending and the tick counter to 0.
REQ-026 The first transition after reset deassertion SHALL occur on the next Clk rising edge.

Configuration
REQ-027 With macro TRAP_SPIKE_EN defined, the spike channel SHALL operate as specified above.
REQ-028 With TRAP_SPIKE_EN undefined, req[2] SHALL be ignored; spike_h, grant[2] and done[2] SHALL be constant 0; spike logic SHALL be absent.

Verification (TICK_DIV=4, STEP=2, PIT_W=8, SPIKE_H=4, TRAP_SPIKE_EN defined unless noted)
REQ-029 Assert reset mid-RUN -> all outputs 0 immediately, with no Clk edge needed.
REQ-030 Pulse req=001 for 1 cycle -> grant=001 next edge; pit1_w steps 2,4,6,8 every 4 clocks; one FINISH cycle; then done=001, busy=0, grant=000.
REQ-031 Pulse req=110 in the same cycle -> pit2 animates to 8 first; spikes are granted on the edge after IDLE and animate to 4; done=110.
REQ-032 Raise death when pit1_w=4 in RUN -> next edge: pit1_w=0, grant=0, done=0, busy=0; pending spikes are discarded.
REQ-033 Pulse req=001 after done[0]=1, and pulse req=001 while pit1 is granted -> no new animation; pit1_w stays 8.
REQ-034 With TRAP_SPIKE_EN undefined, pulse req=100 -> grant stays 000, spike_h stays 0, busy stays 0.
